// File: rtl/exe_stage_mdu_pkg.sv
// Shared encodings for the execute stage: ALU op field, MDU/move opcodes and MDU FSM states.
package exe_stage_mdu_pkg;

    typedef enum logic [2:0] {
        AluAdd = 3'b000,
        AluSub = 3'b001,
        AluAnd = 3'b010,
        AluOr  = 3'b011,
        AluXor = 3'b100,
        AluSll = 3'b101,
        AluSrl = 3'b110,
        AluSra = 3'b111
    } alu_op_e;

    localparam logic [3:0] AlucMultu = 4'b1000;
    localparam logic [3:0] AlucMult  = 4'b1001;
    localparam logic [3:0] AlucDivu  = 4'b1010;
    localparam logic [3:0] AlucDiv   = 4'b1011;
    localparam logic [3:0] AlucMfhi  = 4'b1100;
    localparam logic [3:0] AlucMflo  = 4'b1101;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFin  = 2'b10
    } mdu_state_e;

    function automatic logic is_mdu_op(input logic [3:0] aluc);
        return aluc inside {AlucMultu, AlucMult, AlucDivu, AlucDiv};
    endfunction

endpackage

// File: rtl/exe_stage_mdu_iter.sv
// Iterative radix-2 multiply/divide core: shift-add multiply, restoring divide, one step per cycle,
// operating on magnitudes with sign correction applied in the final cycle.
module exe_stage_mdu_iter
    import exe_stage_mdu_pkg::*;
#(
    parameter int unsigned Width = 32
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic             start,
    input  logic             is_signed,
    input  logic             is_div,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             busy,
    output logic             fin,
    output logic [Width-1:0] hi,
    output logic [Width-1:0] lo
);

    localparam int unsigned CntW = $clog2(Width);
    localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

    mdu_state_e       state_q;
    logic [CntW-1:0]  cnt_q;
    logic [Width-1:0] acc_q, mq_q, opb_q, raw_a_q, hi_q, lo_q;
    logic             sa_q, neg_q, div_q, dz_q, done_q;

    logic             a_neg, b_neg;
    logic [Width-1:0] a_mag, b_mag;
    logic [Width:0]   mul_sum, div_shift, div_diff;
    logic             div_ok;
    logic [Width-1:0] acc_d, mq_d, res_hi, res_lo;
    logic [2*Width-1:0] prod, prod_fix;

    assign a_neg = is_signed & a[Width-1];
    assign b_neg = is_signed & b[Width-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;

    // acc holds the running high half (mul) or partial remainder (div); mq the low half / quotient.
    always_comb begin
        mul_sum   = {1'b0, acc_q} + (mq_q[0] ? {1'b0, opb_q} : '0);
        div_shift = {acc_q, mq_q[Width-1]};
        div_ok    = div_shift >= {1'b0, opb_q};
        div_diff  = div_shift - {1'b0, opb_q};
        if (div_q) begin
            acc_d = Width'(div_ok ? div_diff : div_shift);
            mq_d  = {mq_q[Width-2:0], div_ok};
        end else begin
            acc_d = mul_sum[Width:1];
            mq_d  = {mul_sum[0], mq_q[Width-1:1]};
        end
    end

    always_comb begin
        prod     = {acc_q, mq_q};
        prod_fix = neg_q ? -prod : prod;
        if (!div_q) begin
            {res_hi, res_lo} = prod_fix;
        end else if (dz_q) begin
            res_hi = raw_a_q;
            res_lo = '1;
        end else begin
            res_hi = sa_q ? -acc_q : acc_q;
            res_lo = neg_q ? -mq_q : mq_q;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            acc_q   <= '0;
            mq_q    <= '0;
            opb_q   <= '0;
            raw_a_q <= '0;
            sa_q    <= 1'b0;
            neg_q   <= 1'b0;
            div_q   <= 1'b0;
            dz_q    <= 1'b0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q <= StRun;
                        cnt_q   <= '0;
                        acc_q   <= '0;
                        mq_q    <= a_mag;
                        opb_q   <= b_mag;
                        raw_a_q <= a;
                        sa_q    <= a_neg;
                        neg_q   <= a_neg ^ b_neg;
                        div_q   <= is_div;
                        dz_q    <= is_div & (b == '0);
                    end
                end
                StRun: begin
                    acc_q <= acc_d;
                    mq_q  <= mq_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q <= StFin;
                        done_q  <= 1'b1;
                    end
                end
                StFin: begin
                    hi_q    <= res_hi;
                    lo_q    <= res_lo;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign busy = (state_q == StRun);
    assign fin  = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: rtl/exe_stage_mdu.sv
// Execute stage: single-cycle ALU with shift/immediate operand muxing, HI/LO moves, and a
// multi-cycle multiply/divide unit that stalls the front of the pipe while it runs.
module exe_stage_mdu
    import exe_stage_mdu_pkg::*;
#(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned SA_LSB = 5,
    parameter int unsigned SA_W   = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] ea,
    input  logic [WIDTH-1:0] eb,
    input  logic [WIDTH-1:0] eimm,
    input  logic [3:0]       ealuc,
    input  logic             ealuimm,
    input  logic             eshift,
    input  logic             estart,
    output logic [WIDTH-1:0] ealu,
    output logic             z,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] alu_a, alu_b, alu_res;
    logic [SA_W-1:0]  shamt;
    alu_op_e          alu_op;
    logic             mdu_req, mf_req, mdu_busy, mdu_idle;

    assign alu_a  = eshift ? {{(WIDTH-SA_W){1'b0}}, eimm[SA_LSB +: SA_W]} : ea;
    assign alu_b  = ealuimm ? eimm : eb;
    assign shamt  = alu_a[SA_W-1:0];
    assign alu_op = alu_op_e'(ealuc[2:0]);

    always_comb begin
        alu_res = '0;
        unique case (alu_op)
            AluAdd: alu_res = alu_a + alu_b;
            AluSub: alu_res = alu_a - alu_b;
            AluAnd: alu_res = alu_a & alu_b;
            AluOr:  alu_res = alu_a | alu_b;
            AluXor: alu_res = alu_a ^ alu_b;
            AluSll: alu_res = alu_b << shamt;
            AluSrl: alu_res = alu_b >> shamt;
            AluSra: alu_res = $signed(alu_b) >>> shamt;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        ealu = '0;
        if (!ealuc[3]) begin
            ealu = alu_res;
        end else if (ealuc == AlucMfhi) begin
            ealu = hi;
        end else if (ealuc == AlucMflo) begin
            ealu = lo;
        end
    end

    assign z = (ealu == '0);

    assign mdu_req  = estart & is_mdu_op(ealuc);
    assign mf_req   = estart & ((ealuc == AlucMfhi) | (ealuc == AlucMflo));
    assign mdu_idle = ~mdu_busy & ~done;
    // The issuing MDU op itself sits in EXE during FIN, so only a HI/LO read must still wait there.
    assign stall    = mdu_busy | (mdu_req & mdu_idle) | (mf_req & done);

    exe_stage_mdu_iter #(
        .Width(WIDTH)
    ) u_mdu (
        .clk       (clk),
        .clrn      (clrn),
        .start     (mdu_req),
        .is_signed (ealuc[0]),
        .is_div    (ealuc[1]),
        .a         (ea),
        .b         (eb),
        .busy      (mdu_busy),
        .fin       (done),
        .hi        (hi),
        .lo        (lo)
    );

endmodule

// File: tb/tb_exe_stage_mdu.sv
// Directed bench for exe_stage_mdu: ALU paths, MDU results/latency, reset abort, MFLO hazard.
module tb_exe_stage_mdu;
    import exe_stage_mdu_pkg::*;

    logic        clk, clrn;
    logic [31:0] ea, eb, eimm, ealu, hi, lo;
    logic [3:0]  ealuc;
    logic        ealuimm, eshift, estart, z, stall, done;

    int n_checks = 0;
    int n_pass   = 0;

    exe_stage_mdu #(
        .WIDTH  (32),
        .SA_LSB (5),
        .SA_W   (5)
    ) dut (
        .clk     (clk),
        .clrn    (clrn),
        .ea      (ea),
        .eb      (eb),
        .eimm    (eimm),
        .ealuc   (ealuc),
        .ealuimm (ealuimm),
        .eshift  (eshift),
        .estart  (estart),
        .ealu    (ealu),
        .z       (z),
        .stall   (stall),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic alu_vec(input alu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] imm, input logic useimm, input logic sh);
        @(negedge clk);
        ealuc = {1'b0, op}; ea = a; eb = b; eimm = imm; ealuimm = useimm; eshift = sh;
        estart = 1'b1;
        #1;
    endtask

    // Issue an MDU op, hold it while stalled, return at the first cycle where new hi/lo are visible.
    task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           output int n_stall, output logic done_seen);
        @(negedge clk);
        ealuc = op; ea = a; eb = b; ealuimm = 1'b0; eshift = 1'b0; estart = 1'b1;
        #1;
        n_stall = 0;
        while (stall && n_stall < 100) begin
            n_stall++;
            @(negedge clk);
            #1;
        end
        done_seen = done;
        @(negedge clk);
        estart = 1'b0; ealuc = 4'b0000;
        #1;
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a, b, exp_hi, exp_lo;
        string       tag;
    } mdu_vec_t;

    initial begin
        int       ns;
        int       dcnt;
        logic     dseen;
        mdu_vec_t vecs[$];

        clrn = 1'b0; ea = '0; eb = '0; eimm = '0; ealuc = AlucMflo;
        ealuimm = 1'b0; eshift = 1'b0; estart = 1'b0;
        @(negedge clk);
        #1;
        check_val("rst_stall", stall, 0);
        check_val("rst_done", done, 0);
        check_val("rst_hi", hi, 0);
        check_val("rst_lo", lo, 0);
        check_val("rst_mflo_z", z, 1);
        clrn = 1'b1;

        alu_vec(AluAdd, 5, 7, 0, 0, 0);
        check_val("add_res", ealu, 12);
        check_val("add_z", z, 0);
        check_val("add_stall", stall, 0);
        alu_vec(AluSll, 32'hdead_beef, 1, 32'h80, 0, 1);
        check_val("sll_sa_res", ealu, 16);
        alu_vec(AluSub, 9, 9, 0, 0, 0);
        check_val("sub_res", ealu, 0);
        check_val("sub_z", z, 1);
        alu_vec(AluAnd, 32'hff, 32'hffff_ffff, 32'h0f, 1, 0);
        check_val("and_imm", ealu, 32'h0f);
        alu_vec(AluSra, 4, 32'hf000_0000, 0, 0, 0);
        check_val("sra_res", ealu, 32'hff00_0000);
        alu_vec(AluSrl, 4, 32'h8000_0000, 0, 0, 0);
        check_val("srl_res", ealu, 32'h0800_0000);
        alu_vec(AluXor, 32'h0f0f, 32'h00ff, 0, 0, 0);
        check_val("xor_res", ealu, 32'h0ff0);

        run_mdu(AlucMult, 32'hffff_fffd, 7, ns, dseen);
        check_val("mult_stall_cycles", 64'(ns), 33);
        check_val("mult_done_at_fin", dseen, 1);
        check_val("mult_done_cleared", done, 0);
        check_val("mult_hilo", {hi, lo}, 64'hffff_ffff_ffff_ffeb);
        @(negedge clk);
        ealuc = AlucMfhi; estart = 1'b1;
        #1;
        check_val("mfhi_res", ealu, 32'hffff_ffff);
        check_val("mfhi_stall", stall, 0);

        vecs.push_back('{AlucDiv,   32'hffff_fff9, 2, 32'hffff_ffff, 32'hffff_fffd, "div_neg7_2"});
        vecs.push_back('{AlucDivu,  9, 0, 9, 32'hffff_ffff, "divu_by0"});
        vecs.push_back('{AlucDiv,   7, 32'hffff_fffe, 1, 32'hffff_fffd, "div_7_neg2"});
        vecs.push_back('{AlucDiv,   32'h8000_0000, 32'hffff_ffff, 0, 32'h8000_0000, "div_ovf"});
        vecs.push_back('{AlucDiv,   32'hffff_fffb, 0, 32'hffff_fffb, 32'hffff_ffff, "div_neg_by0"});
        vecs.push_back('{AlucDivu,  100, 7, 2, 14, "divu_100_7"});
        vecs.push_back('{AlucMultu, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe, 1, "multu_max"});
        foreach (vecs[i]) begin
            run_mdu(vecs[i].op, vecs[i].a, vecs[i].b, ns, dseen);
            check_val({vecs[i].tag, "_hilo"}, {hi, lo}, {vecs[i].exp_hi, vecs[i].exp_lo});
            check_val({vecs[i].tag, "_lat"}, 64'(ns), 33);
        end

        // Reset while the MDU is in its tenth RUN cycle.
        @(negedge clk);
        ealuc = AlucMultu; ea = 3; eb = 5; estart = 1'b1;
        repeat (10) @(negedge clk);
        #1;
        check_val("abort_in_run", stall, 1);
        clrn = 1'b0; estart = 1'b0;
        #1;
        check_val("abort_stall", stall, 0);
        check_val("abort_hilo", {hi, lo}, 0);
        check_val("abort_done", done, 0);
        @(negedge clk);
        clrn = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            #1;
            if (done) dcnt++;
        end
        check_val("abort_no_done", 64'(dcnt), 0);
        check_val("abort_lo_kept", lo, 0);

        // MULTU held with new operands during RUN, then MFLO waiting behind it.
        @(negedge clk);
        ealuc = AlucMultu; ea = 6; eb = 7; estart = 1'b1;
        #1;
        ns = 0; dcnt = 0;
        while (stall && ns < 100) begin
            ns++;
            @(negedge clk);
            if (ns < 6) begin
                ea = 100; eb = 100;
            end else begin
                ealuc = AlucMflo;
            end
            #1;
            if (done) dcnt++;
        end
        check_val("hazard_stall_cycles", 64'(ns), 34);
        check_val("hazard_done_count", 64'(dcnt), 1);
        check_val("hazard_mflo", ealu, 42);
        check_val("hazard_hi", hi, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
